mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15, meaning max BUSY cycles awaiting mem_ready before abort (1..255).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port if_req  input  1  fetch-side read request, held until if_ack.
REQ-005 SHALL have port if_addr  input  32  fetch word address.
REQ-006 SHALL have ports if_rdata  output  32  fetch read data, and if_ack  output  1  fetch completion pulse.
REQ-007 SHALL have ports d_req  input  1, d_we  input  1, d_addr  input  32, d_wdata  input  32  data-side request, write-enable, address and write data, held until d_ack.
REQ-008 SHALL have ports d_rdata  output  32  data read data, and d_ack  output  1  data completion pulse.
REQ-009 SHALL have ports mem_req  output  1, mem_we  output  1, mem_addr  output  32, mem_wdata  output  32  shared memory port command.
REQ-010 SHALL have ports mem_rdata  input  32  and mem_ready  input  1  memory response/done.
REQ-011 SHALL have port err  output  1  asserted with ack when transaction aborted by timeout.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY_I, BUSY_D, RESP.
REQ-013 IDLE: if_req or d_req high -> latch winner's addr/we/wdata, go BUSY_I or BUSY_D next cycle; neither -> stay IDLE.
REQ-014 Single requester SHALL always be granted; tie-break per REQ-024.
REQ-015 BUSY_x: mem_req=1 with latched command, stable every cycle until exit; mem_we SHALL be 0 in BUSY_I.
REQ-016 BUSY_x with mem_ready=1: capture mem_rdata (reads), go RESP; mem_req SHALL be 0 from the following cycle.
REQ-017 RESP: exactly one-cycle pulse on granted port's ack; other ack 0; go IDLE; no new grant sampled in RESP.
REQ-018 Latency: request seen in IDLE at cycle 0, mem_req at 1, mem_ready at k>=1, ack at k+1, next grant earliest sampled at k+2.
REQ-019 if_rdata/d_rdata SHALL update only at capture for that port and hold until that port's next capture; write transactions leave d_rdata unchanged.
REQ-020 Timeout: 8-bit counter clears on BUSY entry, increments each BUSY cycle without mem_ready; reaching TIMEOUT_CYCLES -> RESP with err=1, rdata for that port forced to 0; mem_ready in same cycle as limit takes precedence (normal completion, err=0).
REQ-021 err SHALL be 1 only in RESP of aborted transaction, else 0.
REQ-022 Requester dropping req mid-BUSY SHALL not abort the transaction; ack still issued.

Reset
REQ-023 reset high at a clock edge: state IDLE, mem_req/mem_we/if_ack/d_ack/err=0, mem_addr/mem_wdata/if_rdata/d_rdata=0, counter=0, last-grant=fetch; in-flight transaction discarded, no ack issued; reset dominates all other inputs.

Configuration
REQ-024 Macro ARB_ROUND_ROBIN_EN: defined -> on simultaneous if_req and d_req in IDLE, grant the port not granted last (last-grant register updated at each grant); undefined -> data port always wins ties, last-grant register not implemented.

Verification
REQ-025 Fetch alone, if_addr=0x0000_0040, mem_ready on 3rd BUSY cycle, mem_rdata=0x2008_0005 -> mem_req cycles 1-3, if_ack at cycle 4, if_rdata=0x2008_0005, mem_we=0 throughout.
REQ-026 Simultaneous if_req and d_req (d_we=1, d_addr=0x54, d_wdata=0x7) after reset, macro undefined -> data granted first (mem_we=1, mem_addr=0x54), d_ack, then fetch; repeat tie -> data again; macro defined -> data, fetch, data, fetch alternation over 4 ties.
REQ-027 mem_ready held 0, TIMEOUT_CYCLES=4, data read -> mem_req high exactly 4 cycles, d_ack=1 with err=1 and d_rdata=0, IDLE next cycle.
REQ-028 mem_ready asserted on the 4th BUSY cycle with TIMEOUT_CYCLES=4 -> normal completion, err=0, captured data delivered.
REQ-029 reset asserted during BUSY_D -> next cycle mem_req=0, no d_ack ever for that request; after reset released with d_req still high, fresh transaction starts with mem_req one cycle later.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates fetch and data requesters onto one memory port with timeout abort.
// Define ARB_ROUND_ROBIN_EN to alternate grants on ties; otherwise data always wins ties.
module mem_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_addr, r_wdata, r_if_rdata, r_d_rdata;
  logic [7:0]  r_cnt;
  logic        r_we, r_gnt_d, r_err;
  logic        w_busy, w_grant, w_pick_d, w_done, w_timeout;
  assign w_busy    = (r_state == BUSY_I) || (r_state == BUSY_D);
  assign w_grant   = (r_state == IDLE) && (if_req || d_req);
  assign w_timeout = w_busy && !mem_ready && (r_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign w_done    = w_busy && (mem_ready || w_timeout);
`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_d;
  assign w_pick_d = d_req && (!if_req || !r_last_d);
  always_ff @(posedge clk)
    if (reset) r_last_d <= 1'b0;
    else if (w_grant) r_last_d <= w_pick_d;
`else
  assign w_pick_d = d_req;
`endif
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (w_grant ? (w_pick_d ? BUSY_D : BUSY_I) : IDLE)
           : w_busy ? (w_done ? RESP : r_state) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_gnt_d    <= 1'b0;
      r_cnt      <= '0;
      r_err      <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_state <= w_next;
      r_err   <= w_timeout;
      if (w_grant) begin
        r_gnt_d <= w_pick_d;
        r_addr  <= w_pick_d ? d_addr : if_addr;
        r_we    <= w_pick_d && d_we;
        r_wdata <= w_pick_d ? d_wdata : '0;
        r_cnt   <= '0;
      end
      if (w_busy && !mem_ready) r_cnt <= r_cnt + 8'd1;
      // aborted reads return zero; writes never touch read data
      if (w_done && !r_we && r_gnt_d) r_d_rdata <= mem_ready ? mem_rdata : '0;
      if (w_done && !r_gnt_d) r_if_rdata <= mem_ready ? mem_rdata : '0;
    end
  end
  assign mem_req   = w_busy;
  assign mem_we    = w_busy && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign if_ack    = (r_state == RESP) && !r_gnt_d;
  assign d_ack     = (r_state == RESP) && r_gnt_d;
  assign err       = r_err;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed table-driven checks of mem_port_arbiter with TIMEOUT_CYCLES=4.
module tb_mem_port_arbiter;
  logic        clk = 0, reset = 1;
  logic        if_req = 0, d_req = 0, d_we = 0, mem_ready = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, d_ack, mem_req, mem_we, err;
  int ncmp = 0, nbad = 0;

  mem_port_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          we;
    bit          drop;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          rdy_at;
    int          exp_n;
    bit          exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int nreq = 0, cyc = -1;
    bit got = 0, ackd = 0, errv = 0, we_ok = 1, addr_ok = 1, wd_ok = 1;
    logic [31:0] rd = '0;
    string p;
    p = $sformatf("vec%0d", idx);
    @(negedge clk);
    if_req = !v.is_d; d_req = v.is_d; d_we = v.we;
    if_addr = v.addr; d_addr = v.addr; d_wdata = v.wdata;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (mem_req) begin
        nreq++;
        if (mem_we !== (v.is_d && v.we)) we_ok = 0;
        if (mem_addr !== v.addr) addr_ok = 0;
        if (v.is_d && v.we && mem_wdata !== v.wdata) wd_ok = 0;
        if (v.drop && nreq == 1) begin if_req = 0; d_req = 0; end
      end
      if (if_ack || d_ack) begin
        got = 1; cyc = c; ackd = d_ack; errv = err;
        rd = v.is_d ? d_rdata : if_rdata;
      end
      mem_ready = mem_req && (nreq == v.rdy_at);
      mem_rdata = v.rdata;
    end
    if_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
    chk({p, ".ack_seen"}, 32'(got), 32'd1);
    chk({p, ".latency"}, cyc, v.exp_n);
    chk({p, ".mem_req_cycles"}, nreq, v.exp_n);
    chk({p, ".mem_we"}, 32'(we_ok), 32'd1);
    chk({p, ".mem_addr"}, 32'(addr_ok), 32'd1);
    chk({p, ".mem_wdata"}, 32'(wd_ok), 32'd1);
    chk({p, ".ack_port"}, 32'(ackd), 32'(v.is_d));
    chk({p, ".err"}, 32'(errv), 32'(v.exp_err));
    chk({p, ".rdata"}, rd, v.exp_rd);
  endtask

  task automatic tie_grant(input string nm, input bit exp_d);
    bit got = 0, ad = 0, we = 0;
    logic [31:0] a = '0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (if_ack || d_ack) begin got = 1; ad = d_ack; end
      if (mem_req) begin a = mem_addr; we = mem_we; end
      mem_ready = mem_req;
    end
    mem_ready = 0;
    chk({nm, ".ack_seen"}, 32'(got), 32'd1);
    chk({nm, ".port"}, 32'(ad), 32'(exp_d));
    chk({nm, ".addr"}, a, exp_d ? 32'h54 : 32'h80);
    chk({nm, ".we"}, 32'(we), 32'(exp_d));
  endtask

  vec_t vt[7];
  bit   tie_exp[4];
  int   nack;

  initial begin
    vt[0] = '{0, 0, 0, 32'h40,  32'h0, 32'h2008_0005, 3, 3, 0, 32'h2008_0005};
    vt[1] = '{1, 0, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1, 1, 0, 32'hDEAD_BEEF};
    vt[2] = '{1, 1, 0, 32'h54,  32'h7, 32'h1111_1111, 2, 2, 0, 32'hDEAD_BEEF};
    vt[3] = '{1, 0, 0, 32'h104, 32'h0, 32'h5555_5555, 0, 4, 1, 32'h0};
    vt[4] = '{1, 0, 1, 32'h108, 32'h0, 32'hCAFE_0001, 4, 4, 0, 32'hCAFE_0001};
    vt[5] = '{0, 0, 0, 32'h44,  32'h0, 32'h7777_7777, 5, 4, 1, 32'h0};
    vt[6] = '{0, 0, 0, 32'h48,  32'h0, 32'h1234_5678, 1, 1, 0, 32'h1234_5678};
`ifdef ARB_ROUND_ROBIN_EN
    tie_exp = '{1, 0, 1, 0};
`else
    tie_exp = '{1, 1, 1, 1};
`endif
    repeat (2) @(negedge clk);
    chk("rst.mem_req", 32'(mem_req), 0);
    chk("rst.mem_we", 32'(mem_we), 0);
    chk("rst.acks", {30'd0, if_ack, d_ack}, 0);
    chk("rst.err", 32'(err), 0);
    chk("rst.mem_addr", mem_addr, 0);
    chk("rst.mem_wdata", mem_wdata, 0);
    chk("rst.if_rdata", if_rdata, 0);
    chk("rst.d_rdata", d_rdata, 0);
    reset = 0;
    for (int i = 0; i < 7; i++) run_vec(i, vt[i]);
    @(negedge clk);
    chk("post.d_rdata_kept", d_rdata, 32'hCAFE_0001);
    // tie with the acked port withdrawing, then both re-raised
    if_addr = 32'h80; d_addr = 32'h54; d_wdata = 32'h7; d_we = 1;
    if_req = 1; d_req = 1;
    tie_grant("tieA0", 1);
    d_req = 0;
    tie_grant("tieA1", 0);
    d_req = 1;
    tie_grant("tieA2", 1);
    reset = 1;
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 4; i++) tie_grant($sformatf("tieB%0d", i), tie_exp[i]);
    if_req = 0; d_req = 0; d_we = 0;
    // reset while a data read is in flight
    reset = 1;
    @(negedge clk);
    reset = 0;
    d_req = 1; d_addr = 32'h200;
    nack = 0;
    repeat (2) begin @(negedge clk); nack += int'(d_ack); end
    chk("rstbusy.in_busy", 32'(mem_req), 1);
    reset = 1;
    @(negedge clk);
    nack += int'(d_ack);
    chk("rstbusy.mem_req_off", 32'(mem_req), 0);
    reset = 0;
    @(negedge clk);
    chk("rstbusy.restart", 32'(mem_req), 1);
    chk("rstbusy.addr", mem_addr, 32'h200);
    mem_ready = 1; mem_rdata = 32'h0000_ABCD;
    @(negedge clk);
    nack += int'(d_ack);
    chk("rstbusy.ack", 32'(d_ack), 1);
    chk("rstbusy.rdata", d_rdata, 32'h0000_ABCD);
    d_req = 0; mem_ready = 0;
    repeat (3) begin @(negedge clk); nack += int'(d_ack); end
    chk("rstbusy.ack_count", nack, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
